// File: rtl/uart_tx_pkg.sv
// Shared types and limits for the UART transmitter: FSM encoding and legal frame parameters.
// Pure definitions, no logic and no timing.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int MIN_DATA_SIZE  = 5;
   localparam int MAX_DATA_SIZE  = 8;
   localparam int MIN_BIT_PERIOD = 2;

   // Out-of-range payload sizes fall back to a full byte.
   function automatic logic [3:0] legal_size(input logic [3:0] ds);
      if (ds < 4'(MIN_DATA_SIZE) || ds > 4'(MAX_DATA_SIZE))
         return 4'(MAX_DATA_SIZE);
      return ds;
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Up-counter 0..rollover_val that wraps on enable; rollover_flag marks the terminal count.
// Flag is combinational from the count register; clear has priority over count_enable.
module flex_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             count_enable,
   input  logic [WIDTH-1:0] rollover_val,
   output logic             rollover_flag
);

   logic [WIDTH-1:0] count;

   assign rollover_flag = (count == rollover_val);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (count_enable)
         count <= rollover_flag ? '0 : count + WIDTH'(1);
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 LSB-first data bits, one stop bit, runtime bit period.
// Frame begins on the edge after tx_start in IDLE; requests while busy are dropped.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int BP_WIDTH = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tx_start,
   input  logic [7:0]          tx_data,
   input  logic [3:0]          data_size,
   input  logic [BP_WIDTH-1:0] bit_period,
   output logic                serial_out,
   output logic                busy,
   output logic                tx_done
);

   state_t              state, next_state;
   logic [7:0]          shreg;
   logic [3:0]          size_r;
   logic [BP_WIDTH-1:0] period_r;
   logic [BP_WIDTH-1:0] bp_eff;
   logic [BP_WIDTH-1:0] timer_roll;
   logic [2:0]          idx_roll;
   logic                in_idle, in_data;
   logic                bit_tick, last_bit, idx_enable;
   logic                serial_nxt;

   assign bp_eff     = (bit_period < BP_WIDTH'(MIN_BIT_PERIOD)) ? BP_WIDTH'(MIN_BIT_PERIOD) : bit_period;
   assign timer_roll = period_r - BP_WIDTH'(1);
   assign idx_roll   = 3'(size_r - 4'd1);
   assign in_idle    = (state == IDLE);
   assign in_data    = (state == DATA);
   assign idx_enable = in_data && bit_tick;

   // bit_tick is high on the last clock of every serial bit
   flex_counter #(.WIDTH(BP_WIDTH)) bit_timer (
      .clk           (clk),
      .rst           (rst),
      .clear         (in_idle),
      .count_enable  (!in_idle),
      .rollover_val  (timer_roll),
      .rollover_flag (bit_tick)
   );

   flex_counter #(.WIDTH(3)) bit_index (
      .clk           (clk),
      .rst           (rst),
      .clear         (in_idle),
      .count_enable  (idx_enable),
      .rollover_val  (idx_roll),
      .rollover_flag (last_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (tx_start)             next_state = START;
         START:   if (bit_tick)             next_state = DATA;
         DATA:    if (bit_tick && last_bit) next_state = STOP;
         STOP:    if (bit_tick)             next_state = IDLE;
         default:                           next_state = IDLE;
      endcase
   end

   // serial_nxt looks one edge ahead so the line itself can come straight from a flop
   always_comb begin
      busy       = !in_idle;
      tx_done    = (state == STOP) && bit_tick;
      serial_nxt = 1'b1;
      case (next_state)
         START:   serial_nxt = 1'b0;
         DATA:    serial_nxt = idx_enable ? shreg[1] : shreg[0];
         default: serial_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         serial_out <= 1'b1;
         shreg      <= '0;
         size_r     <= '0;
         period_r   <= '0;
      end else begin
         serial_out <= serial_nxt;
         if (in_idle && tx_start) begin
            shreg    <= tx_data;
            size_r   <= legal_size(data_size);
            period_r <= bp_eff;
         end else if (idx_enable) begin
            shreg <= {1'b0, shreg[7:1]};
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle frame model compared every cycle, directed frames pinned
// against hand-computed line patterns, then randomized start/payload/size/period traffic.
module tb_uart_tx;

   logic        tb_clk = 1'b0;
   logic        rst;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [3:0]  data_size;
   logic [13:0] bit_period;
   logic        serial_out, busy, tx_done;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   bit chk_en   = 1'b0;

   typedef struct packed {
      logic line;
      logic bsy;
      logic done;
   } smp_t;

   smp_t exp_q[$];
   logic rec[$];
   int   wait_cyc;
   int   done_pos;

   always #5 tb_clk = ~tb_clk;

   uart_tx #(.BP_WIDTH(14)) dut (
      .clk        (tb_clk),
      .rst        (rst),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .data_size  (data_size),
      .bit_period (bit_period),
      .serial_out (serial_out),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // One entry per clock of the frame: line level, busy, tx_done.
   function automatic void push_frame(input logic [7:0] d, input logic [3:0] ds, input logic [13:0] bp);
      int size, per, total;
      size  = (ds >= 5 && ds <= 8) ? int'(ds) : 8;
      per   = (bp < 2) ? 2 : int'(bp);
      total = (size + 2) * per;
      for (int c = 0; c < total; c++) begin
         int   b;
         smp_t s;
         b      = c / per;
         s.bsy  = 1'b1;
         s.done = (c == total - 1);
         if (b == 0)
            s.line = 1'b0;
         else if (b == size + 1)
            s.line = 1'b1;
         else
            s.line = d[b-1];
         exp_q.push_back(s);
      end
   endfunction

   always @(posedge tb_clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         bit was_idle;
         was_idle = (exp_q.size() == 0);
         if (!was_idle)
            void'(exp_q.pop_front());
         if (was_idle && tx_start)
            push_frame(tx_data, data_size, bit_period);
      end
   end

   always @(negedge tb_clk) begin
      if (chk_en && !rst) begin
         smp_t e;
         e = (exp_q.size() != 0) ? exp_q[0] : smp_t'(3'b100);
         check("model_serial_out", serial_out, e.line);
         check("model_busy",       busy,       e.bsy);
         check("model_tx_done",    tx_done,    e.done);
      end
   end

   always @(negedge tb_clk)
      if (tx_done) done_cnt++;

   function automatic int ones_in_rec();
      int n = 0;
      foreach (rec[i]) if (rec[i] === 1'b1) n++;
      return n;
   endfunction

   // Launches a frame from the current (idle) cycle and records the line while busy.
   task automatic do_frame(input logic [7:0] d, input logic [3:0] ds, input logic [13:0] bp);
      tx_data    = d;
      data_size  = ds;
      bit_period = bp;
      tx_start   = 1'b1;
      @(posedge tb_clk);
      #1 tx_start = 1'b0;
      rec.delete();
      wait_cyc = 0;
      done_pos = -1;
      @(negedge tb_clk);
      while (!busy && wait_cyc < 50) begin
         wait_cyc++;
         @(negedge tb_clk);
      end
      check("frame_start_seen", busy, 1);
      while (busy && rec.size() < 2000) begin
         if (tx_done) done_pos = rec.size() + 1;
         rec.push_back(serial_out);
         @(negedge tb_clk);
      end
      check("frame_end_seen", busy, 0);
   endtask

   initial begin
      logic [9:0] pat_a5;
      int         d0;
      pat_a5     = 10'b1101001010;
      rst        = 1'b0;
      tx_start   = 1'b0;
      tx_data    = 8'h00;
      data_size  = 4'd8;
      bit_period = 14'd4;

      #2 rst = 1'b1;
      #1;
      check("reset_serial_out", serial_out, 1);
      check("reset_busy",       busy,       0);
      check("reset_tx_done",    tx_done,    0);
      repeat (2) @(posedge tb_clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge tb_clk);

      do_frame(8'hA5, 4'd8, 14'd4);
      check("a5_len",      rec.size(), 40);
      check("a5_done_pos", done_pos,   40);
      for (int c = 0; c < 40; c++)
         check("a5_line", rec[c], pat_a5[c/4]);

      do_frame(8'hFF, 4'd5, 14'd3);
      check("ff5_len",      rec.size(),    21);
      check("ff5_done_pos", done_pos,      21);
      check("ff5_ones",     ones_in_rec(), 18);

      fork
         do_frame(8'h00, 4'd8, 14'd3);
         begin
            repeat (8) @(posedge tb_clk);
            #1 tx_data = 8'hFF;
            tx_start   = 1'b1;
            @(posedge tb_clk);
            #1 tx_start = 1'b0;
         end
      join
      check("ignore_len",  rec.size(),    30);
      check("ignore_ones", ones_in_rec(), 3);
      repeat (6) begin
         @(negedge tb_clk);
         check("ignore_no_second_frame", busy, 0);
      end

      do_frame(8'h01, 4'd8, 14'd2);
      check("b2b_first_len",  rec.size(),    20);
      check("b2b_first_bit0", rec[2],        1);
      check("b2b_first_ones", ones_in_rec(), 4);
      check("b2b_gap_idle",   busy,          0);
      do_frame(8'h80, 4'd8, 14'd2);
      check("b2b_second_wait", wait_cyc,      0);
      check("b2b_second_len",  rec.size(),    20);
      check("b2b_second_bit6", rec[15],       0);
      check("b2b_second_bit7", rec[16],       1);
      check("b2b_second_ones", ones_in_rec(), 4);

      do_frame(8'h3C, 4'hF, 14'd0);
      check("clamp_len",      rec.size(), 20);
      check("clamp_done_pos", done_pos,   20);

      tx_data    = 8'hA5;
      data_size  = 4'd8;
      bit_period = 14'd4;
      tx_start   = 1'b1;
      @(posedge tb_clk);
      #1 tx_start = 1'b0;
      repeat (10) @(posedge tb_clk);
      check("abort_in_data_line", serial_out, 0);
      d0 = done_cnt;
      #3 rst = 1'b1;
      #1;
      check("abort_serial_out", serial_out, 1);
      check("abort_busy",       busy,       0);
      check("abort_tx_done",    tx_done,    0);
      repeat (2) @(posedge tb_clk);
      #1 rst = 1'b0;
      repeat (12) begin
         @(negedge tb_clk);
         check("abort_stays_idle", busy, 0);
      end
      check("abort_no_done", done_cnt, d0);

      repeat (3000) begin
         @(posedge tb_clk);
         #1;
         tx_start   = ($urandom_range(0, 3) == 0);
         tx_data    = 8'($urandom);
         data_size  = 4'($urandom_range(0, 15));
         bit_period = 14'($urandom_range(0, 5));
      end
      #1 tx_start = 1'b0;
      repeat (100) @(posedge tb_clk);
      @(negedge tb_clk);
      check("drain_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
